// File: rtl/div_arb.sv
// div_arb: round-robin arbiter sharing one signed divider between two requesters
module div_arb #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] dividend0,
    input  logic [31:0] dividend1,
    input  logic [15:0] divisor0,
    input  logic [15:0] divisor1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] quotient,
    output logic        ovf,
    output logic        dz,
    output logic        to,
    output logic        div_ready,
    output logic [31:0] div_dividend,
    output logic [15:0] div_divisor,
    input  logic        div_done,
    input  logic [31:0] div_quotient
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [31:0] dvd;
    logic [15:0] dvs, quot;
    logic id, last, ovf_q, dz_q, to_q, gnt1, tmo;

    // requester 1 wins alone, or on a tie when requester 0 was served last
    assign gnt1 = req1 && (!req0 || !last);
    assign tmo = cnt == CW'(TIMEOUT - 1);
    assign quotient = quot;
    assign div_dividend = dvd;
    assign div_divisor = dvs;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end

    // next state and response/strobe outputs
    always_comb begin
        nxt = state;
        ack0 = 1'b0;
        ack1 = 1'b0;
        ovf = 1'b0;
        dz = 1'b0;
        to = 1'b0;
        div_ready = 1'b0;
        case (state)
            IDLE: nxt = (req0 || req1) ? START : IDLE;
            START: begin
                nxt = (dvs == 16'd0) ? RESP : WAIT;
                div_ready = dvs != 16'd0;
            end
            WAIT: nxt = (div_done || tmo) ? RESP : WAIT;
            RESP: begin
                nxt = IDLE;
                ack0 = !id;
                ack1 = id;
                ovf = ovf_q;
                dz = dz_q;
                to = to_q;
            end
            default: nxt = IDLE;
        endcase
    end

    // operand latch, wait counter, result capture and last-served pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            dvd <= '0;
            dvs <= '0;
            quot <= '0;
            id <= 1'b0;
            last <= 1'b1;
            {ovf_q, dz_q, to_q} <= 3'b000;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    id <= gnt1;
                    dvd <= gnt1 ? dividend1 : dividend0;
                    dvs <= gnt1 ? divisor1 : divisor0;
                end
                START: begin
                    cnt <= '0;
                    if (dvs == 16'd0) {ovf_q, dz_q, to_q, quot} <= {3'b110, 16'd0};
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (div_done) begin
                        quot <= div_quotient[15:0];
                        ovf_q <= !(&div_quotient[31:15] || ~|div_quotient[31:15]);
                        {dz_q, to_q} <= 2'b00;
                    end else if (tmo) begin
                        {ovf_q, dz_q, to_q, quot} <= {3'b101, 16'd0};
                    end
                end
                RESP: last <= id;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_arb.sv
// tb_div_arb: randomized self-checking bench for div_arb with a 32-cycle stub divider
module tb_div_arb;
    localparam int TMO = 40;

    logic        clk = 1'b0, reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] dividend0 = '0, dividend1 = '0;
    logic [15:0] divisor0 = '0, divisor1 = '0;
    logic        ack0, ack1, ovf, dz, to, div_ready, div_done;
    logic [15:0] quotient, div_divisor;
    logic [31:0] div_dividend, div_quotient;
    int total = 0, bad = 0;

    logic stall = 1'b0, force_done = 1'b0;
    int dcnt = 0;
    logic [31:0] dres = '0;

    div_arb #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .dividend0(dividend0), .dividend1(dividend1), .divisor0(divisor0), .divisor1(divisor1),
        .ack0(ack0), .ack1(ack1), .quotient(quotient), .ovf(ovf), .dz(dz), .to(to),
        .div_ready(div_ready), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hw_div(input logic [31:0] a, input logic [15:0] b);
        longint r;
        if (b == 16'd0) return 32'd0;
        r = longint'($signed(a)) / longint'($signed(b));
        return r[31:0];
    endfunction

    // stub divider: done pulse 33 cycles after the start strobe
    always @(posedge clk) begin
        if (reset) dcnt <= 0;
        else if (div_ready) begin
            dcnt <= 33;
            dres <= hw_div(div_dividend, div_divisor);
        end else if (dcnt > 0) dcnt <= dcnt - 1;
    end
    assign div_done = force_done || (!stall && dcnt == 1);
    assign div_quotient = dres;

    function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic ov, output logic z);
        longint r;
        if (b == 16'd0) begin
            q = 16'd0; ov = 1'b1; z = 1'b1;
        end else begin
            r = longint'($signed(a)) / longint'($signed(b));
            q = r[15:0];
            ov = (r > 32767) || (r < -32768);
            z = 1'b0;
        end
    endfunction

    task automatic reset_dut();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // starts an op in the current IDLE cycle, returns what the DUT showed at ack and one cycle later
    task automatic issue(input bit who, input logic [31:0] a, input logic [15:0] b,
                         output int lat, output int rdy, output logic a0, output logic a1,
                         output logic [15:0] q, output logic ov, output logic z, output logic t,
                         output logic [15:0] q_after, output logic any_after);
        if (who) begin dividend1 = a; divisor1 = b; req1 = 1'b1; end
        else begin dividend0 = a; divisor0 = b; req0 = 1'b1; end
        lat = -1; rdy = -1; a0 = 0; a1 = 0; q = 'x; ov = 'x; z = 'x; t = 'x;
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (div_ready && rdy < 0) rdy = n;
            if (ack0 || ack1) begin
                lat = n; a0 = ack0; a1 = ack1; q = quotient; ov = ovf; z = dz; t = to;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        q_after = quotient;
        any_after = ack0 | ack1 | ovf | dz | to;
    endtask

    task automatic test_reset();
        reset_dut();
        total++; if ({ack0, ack1, ovf, dz, to, div_ready} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b want=000000", {ack0, ack1, ovf, dz, to, div_ready}); end
        total++; if (quotient !== 16'd0) begin bad++; $display("FAIL reset_quotient got=%h want=0000", quotient); end
        total++; if ({div_dividend, div_divisor} !== 48'd0) begin bad++; $display("FAIL reset_operands got=%h want=0", {div_dividend, div_divisor}); end
    endtask

    task automatic test_basic();
        int lat, rdy; logic a0, a1, ov, z, t, anya; logic [15:0] q, qa;
        issue(0, 32'd100, 16'd7, lat, rdy, a0, a1, q, ov, z, t, qa, anya);
        total++; if (rdy !== 1) begin bad++; $display("FAIL basic_ready_cycle got=%0d want=1", rdy); end
        total++; if (lat !== 35) begin bad++; $display("FAIL basic_latency got=%0d want=35", lat); end
        total++; if ({a0, a1} !== 2'b10) begin bad++; $display("FAIL basic_ack got=%b want=10", {a0, a1}); end
        total++; if (q !== 16'd14) begin bad++; $display("FAIL basic_quotient got=%0d want=14", q); end
        total++; if ({ov, z, t} !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b want=000", {ov, z, t}); end
        total++; if (qa !== 16'd14 || anya !== 1'b0) begin bad++; $display("FAIL basic_hold got q=%0d strobes=%b want q=14 strobes=0", qa, anya); end
    endtask

    task automatic test_neg();
        int lat, rdy; logic a0, a1, ov, z, t, anya; logic [15:0] q, qa;
        issue(1, -32'sd200, 16'd3, lat, rdy, a0, a1, q, ov, z, t, qa, anya);
        total++; if ({a0, a1} !== 2'b01) begin bad++; $display("FAIL neg_ack got=%b want=01", {a0, a1}); end
        total++; if (q !== 16'hFFBE) begin bad++; $display("FAIL neg_quotient got=%h want=ffbe", q); end
        total++; if ({ov, z, t} !== 3'b000 || lat !== 35) begin bad++; $display("FAIL neg_flags_lat got=%b/%0d want=000/35", {ov, z, t}, lat); end
    endtask

    task automatic test_dz();
        int lat, rdy; logic a0, a1, ov, z, t, anya; logic [15:0] q, qa;
        issue(0, 32'd1234, 16'd0, lat, rdy, a0, a1, q, ov, z, t, qa, anya);
        total++; if (lat !== 2) begin bad++; $display("FAIL dz_latency got=%0d want=2", lat); end
        total++; if (rdy !== -1) begin bad++; $display("FAIL dz_ready got=%0d want=never", rdy); end
        total++; if ({a0, a1, ov, z, t} !== 5'b10110 || q !== 16'd0) begin bad++; $display("FAIL dz_result got=%b q=%h want=10110 q=0000", {a0, a1, ov, z, t}, q); end
    endtask

    task automatic test_ovf();
        int lat, rdy; logic a0, a1, ov, z, t, anya; logic [15:0] q, qa;
        issue(0, 32'h7FFFFFFF, 16'd1, lat, rdy, a0, a1, q, ov, z, t, qa, anya);
        total++; if ({ov, z, t} !== 3'b100) begin bad++; $display("FAIL ovf_flags got=%b want=100", {ov, z, t}); end
        total++; if (q !== 16'hFFFF) begin bad++; $display("FAIL ovf_quotient got=%h want=ffff", q); end
    endtask

    task automatic test_timeout();
        int lat, rdy; logic a0, a1, ov, z, t, anya; logic [15:0] q, qa;
        stall = 1'b1;
        issue(1, 32'd500, 16'd5, lat, rdy, a0, a1, q, ov, z, t, qa, anya);
        stall = 1'b0;
        total++; if (lat !== 2 + TMO) begin bad++; $display("FAIL timeout_latency got=%0d want=%0d", lat, 2 + TMO); end
        total++; if ({a0, a1, ov, z, t} !== 5'b01101 || q !== 16'd0) begin bad++; $display("FAIL timeout_result got=%b q=%h want=01101 q=0000", {a0, a1, ov, z, t}, q); end
    endtask

    task automatic test_spurious_done();
        int lat, rdy, hits = 0; logic a0, a1, ov, z, t, anya; logic [15:0] q, qa;
        force_done = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (ack0 || ack1) hits++; end
        force_done = 1'b0;
        total++; if (hits !== 0) begin bad++; $display("FAIL idle_done_ack got=%0d want=0", hits); end
        issue(0, 32'd90, 16'd9, lat, rdy, a0, a1, q, ov, z, t, qa, anya);
        total++; if (lat !== 35 || q !== 16'd10) begin bad++; $display("FAIL after_idle_done got lat=%0d q=%0d want lat=35 q=10", lat, q); end
    endtask

    task automatic test_round_robin();
        int n = 0, k = 0;
        reset_dut();
        dividend0 = 32'd100; divisor0 = 16'd7; dividend1 = -32'sd200; divisor1 = 16'd3;
        req0 = 1'b1; req1 = 1'b1;
        while (k < 4 && n < 100) begin
            @(posedge clk); #1; n++;
            if (ack0 || ack1) begin
                total++; if ({ack0, ack1} !== ((k % 2) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_order_%0d got=%b want=%b", k, {ack0, ack1}, (k % 2) ? 2'b01 : 2'b10); end
                total++; if (quotient !== ((k % 2) ? 16'hFFBE : 16'd14)) begin bad++; $display("FAIL rr_quotient_%0d got=%h", k, quotient); end
                total++; if (n !== (k == 0 ? 35 : 36)) begin bad++; $display("FAIL rr_gap_%0d got=%0d want=%0d", k, n, k == 0 ? 35 : 36); end
                k++; n = 0;
            end
        end
        total++; if (k !== 4) begin bad++; $display("FAIL rr_count got=%0d want=4", k); end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int lat, rdy, hits = 0; logic a0, a1, ov, z, t, anya; logic [15:0] q, qa;
        dividend0 = 32'd100; divisor0 = 16'd7; req0 = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if ({ack0, ack1, ovf, dz, to, div_ready} !== 6'b0 || quotient !== 16'd0 || div_dividend !== 32'd0) begin bad++; $display("FAIL midreset_outputs got=%b q=%h dvd=%h want=0", {ack0, ack1, ovf, dz, to, div_ready}, quotient, div_dividend); end
        req0 = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (ack0 || ack1) hits++; end
        total++; if (hits !== 0) begin bad++; $display("FAIL midreset_noack got=%0d want=0", hits); end
        issue(0, 32'd100, 16'd7, lat, rdy, a0, a1, q, ov, z, t, qa, anya);
        total++; if (lat !== 35 || q !== 16'd14 || a0 !== 1'b1) begin bad++; $display("FAIL midreset_recover got lat=%0d q=%0d ack0=%b want 35/14/1", lat, q, a0); end
    endtask

    task automatic test_random();
        int lat, rdy; logic a0, a1, ov, z, t, anya, eov, ez; logic [15:0] q, qa, eq, b; logic [31:0] a; bit who;
        for (int i = 0; i < 10; i++) begin
            who = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 1)) a = {{16{a[15]}}, a[15:0]};
            b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            ref_div(a, b, eq, eov, ez);
            issue(who, a, b, lat, rdy, a0, a1, q, ov, z, t, qa, anya);
            total++; if ({a0, a1} !== {!who, who} || lat !== (ez ? 2 : 35)) begin bad++; $display("FAIL rand_%0d_ack got=%b lat=%0d want=%b lat=%0d", i, {a0, a1}, lat, {!who, who}, ez ? 2 : 35); end
            total++; if (q !== eq || {ov, z, t} !== {eov, ez, 1'b0}) begin bad++; $display("FAIL rand_%0d_result %h/%h got q=%h f=%b want q=%h f=%b", i, a, b, q, {ov, z, t}, eq, {eov, ez, 1'b0}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg();
        test_dz();
        test_ovf();
        test_timeout();
        test_spurious_done();
        test_round_robin();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
